// File: rtl/vida_regressiva.sv
// Lives-remaining tracker: loads lives on start, decrements on hit edges with an invulnerability window.
// Optional build macro VIDA_BONUS_EN enables the bonus (extra-life) rising-edge increment.
module vida_regressiva #(
  parameter int MAX_VIDAS    = 3,
  parameter int WIDTH        = 2,
  parameter int INVUL_CICLOS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 dano,
  input  logic                 bonus,
  output logic [WIDTH-1:0]     vidas,
  output logic [MAX_VIDAS-1:0] leds,
  output logic                 fim_jogo,
  output logic                 invulneravel
);

  localparam int TW = (INVUL_CICLOS < 1) ? 1 : $clog2(INVUL_CICLOS + 1);
  localparam logic [WIDTH-1:0] VIDAS_CHEIA = WIDTH'(MAX_VIDAS);
  localparam logic [TW-1:0]    TIMER_CARGA = TW'(INVUL_CICLOS);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] JOGANDO = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          dano_q;
  logic          hit;
  logic          hit_ok;
  logic          extra;

  function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
    return (v >= VIDAS_CHEIA) ? VIDAS_CHEIA : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  assign hit    = dano & ~dano_q;
  assign hit_ok = hit & (timer == '0);

`ifdef VIDA_BONUS_EN
  logic bonus_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bonus_q <= 1'b1;
    else        bonus_q <= bonus;
  end

  assign extra = bonus & ~bonus_q;
`else
  logic unused_bonus;
  assign unused_bonus = bonus;
  assign extra        = 1'b0;
`endif

  // Edge history preset high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= OCIOSO;
      vidas    <= '0;
      fim_jogo <= 1'b0;
      timer    <= '0;
      dano_q   <= 1'b1;
    end else begin
      dano_q <= dano;
      if (timer != '0) timer <= timer - TW'(1);

      if (iniciar) begin
        state    <= JOGANDO;
        vidas    <= VIDAS_CHEIA;
        fim_jogo <= 1'b0;
        timer    <= '0;
      end else if (state == JOGANDO) begin
        if (hit_ok) begin
          timer <= TIMER_CARGA;
          // A simultaneous extra life cancels the loss but not the invulnerability window.
          if (!extra) begin
            vidas <= dec_sat(vidas);
            if (vidas == WIDTH'(1)) begin
              state    <= FIM;
              fim_jogo <= 1'b1;
            end
          end
        end else if (extra) begin
          vidas <= inc_sat(vidas);
        end
      end
    end
  end

  always_comb begin
    leds = '0;
    for (int i = 0; i < MAX_VIDAS; i++) leds[i] = (int'(vidas) > i);
  end

  assign invulneravel = (timer != '0);

endmodule

// File: tb/tb_vida_regressiva.sv
// Randomized self-checking bench for vida_regressiva against a lives/timer reference model.
// Honors VIDA_BONUS_EN the same way the design does.
`timescale 1ns/1ps
module tb_vida_regressiva;

  localparam int MAX_VIDAS    = 3;
  localparam int WIDTH        = 2;
  localparam int INVUL_CICLOS = 4;

  logic                 clock   = 1'b0;
  logic                 reset   = 1'b0;
  logic                 iniciar = 1'b0;
  logic                 dano    = 1'b0;
  logic                 bonus   = 1'b0;
  logic [WIDTH-1:0]     vidas;
  logic [MAX_VIDAS-1:0] leds;
  logic                 fim_jogo;
  logic                 invulneravel;

  int n_checks = 0;
  int n_fail   = 0;

  vida_regressiva #(
    .MAX_VIDAS   (MAX_VIDAS),
    .WIDTH       (WIDTH),
    .INVUL_CICLOS(INVUL_CICLOS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .dano        (dano),
    .bonus       (bonus),
    .vidas       (vidas),
    .leds        (leds),
    .fim_jogo    (fim_jogo),
    .invulneravel(invulneravel)
  );

  always #5 clock = ~clock;

  // Reference model: game mode, life count, remaining invulnerable cycles, last input levels.
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  int m_mode;
  int m_lives;
  int m_tmr;
  bit m_dprev;
  bit m_bprev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_lives = 0;
    m_tmr   = 0;
    m_dprev = 1'b1;
    m_bprev = 1'b1;
  endtask

  task automatic model_edge(input bit i, input bit d, input bit b);
    bit h;
    bit e;
    bit grab;
    h = d && !m_dprev;
    e = b && !m_bprev;
`ifndef VIDA_BONUS_EN
    e = 1'b0;
`endif
    m_dprev = d;
    m_bprev = b;
    grab = !i && (m_mode == M_PLAY) && h && (m_tmr == 0);
    if (m_tmr > 0) m_tmr--;
    if (i) begin
      m_mode  = M_PLAY;
      m_lives = MAX_VIDAS;
      m_tmr   = 0;
    end else if (m_mode == M_PLAY) begin
      if (grab) begin
        m_tmr   = INVUL_CICLOS;
        m_lives = m_lives - 1;
      end
      if (e) m_lives = (m_lives + 1 > MAX_VIDAS) ? MAX_VIDAS : m_lives + 1;
      if (m_lives == 0) m_mode = M_OVER;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".vidas"}, 32'(vidas), 32'(m_lives));
    chk({ctx, ".leds"}, 32'(leds), 32'((1 << m_lives) - 1));
    chk({ctx, ".fim_jogo"}, 32'(fim_jogo), 32'(m_mode == M_OVER));
    chk({ctx, ".invulneravel"}, 32'(invulneravel), 32'(m_tmr > 0));
  endtask

  // Called right after a falling edge; drives inputs, applies one rising edge, checks at the next falling edge.
  task automatic step(input bit i, input bit d, input bit b, input string ctx);
    iniciar = i;
    dano    = d;
    bonus   = b;
    @(posedge clock);
    model_edge(i, d, b);
    @(negedge clock);
    check_all(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, ctx);
  endtask

  task automatic async_reset(input bit d, input string ctx);
    iniciar = 1'b0;
    dano    = d;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all(ctx);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // Start from idle
    step(1'b0, 1'b0, 1'b0, "idle");
    step(1'b1, 1'b0, 1'b0, "start");
    chk("start.vidas_lit", 32'(vidas), 32'd3);
    chk("start.leds_lit", 32'(leds), 32'b111);

    // Three spaced hits to game over, then hits ignored
    step(1'b0, 1'b0, 1'b0, "t2");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, "t2.hit");
      idle(5, "t2.gap");
    end
    chk("t2.fim_lit", 32'(fim_jogo), 32'd1);
    step(1'b0, 1'b1, 1'b0, "t2.late");
    idle(2, "t2.late_gap");
    chk("t2.vidas_zero", 32'(vidas), 32'd0);

    // Hit inside the invulnerability window is dropped
    step(1'b1, 1'b0, 1'b0, "t3.start");
    step(1'b0, 1'b1, 1'b0, "t3.hit1");
    step(1'b0, 1'b0, 1'b0, "t3.a");
    step(1'b0, 1'b1, 1'b0, "t3.hit2");
    chk("t3.dropped", 32'(vidas), 32'd2);
    step(1'b0, 1'b0, 1'b0, "t3.b");
    step(1'b0, 1'b0, 1'b0, "t3.c");
    step(1'b0, 1'b1, 1'b0, "t3.hit3");
    chk("t3.accepted", 32'(vidas), 32'd1);
    idle(5, "t3.tail");

`ifdef VIDA_BONUS_EN
    step(1'b1, 1'b0, 1'b0, "t4.start");
    step(1'b0, 1'b1, 1'b0, "t4.hit");
    idle(5, "t4.gap");
    step(1'b0, 1'b0, 1'b1, "t4.bonus1");
    chk("t4.bonus_up", 32'(vidas), 32'd3);
    step(1'b0, 1'b0, 1'b0, "t4.a");
    step(1'b0, 1'b0, 1'b1, "t4.bonus2");
    chk("t4.saturate", 32'(vidas), 32'd3);
    step(1'b0, 1'b0, 1'b0, "t4.b");
    step(1'b0, 1'b1, 1'b1, "t4.both");
    chk("t4.both_vidas", 32'(vidas), 32'd3);
    chk("t4.both_invul", 32'(invulneravel), 32'd1);
    idle(4, "t4.window");
    chk("t4.window_end", 32'(invulneravel), 32'd0);
`endif

    // Async reset mid-game with one life and timer 3, dano held through release
    step(1'b1, 1'b0, 1'b0, "t5.start");
    step(1'b0, 1'b1, 1'b0, "t5.hit1");
    idle(5, "t5.gap");
    step(1'b0, 1'b1, 1'b0, "t5.hit2");
    step(1'b0, 1'b0, 1'b0, "t5.t3");
    chk("t5.pre_vidas", 32'(vidas), 32'd1);
    async_reset(1'b1, "t5.rst");
    step(1'b0, 1'b1, 1'b0, "t5.held");
    step(1'b1, 1'b1, 1'b0, "t5.restart");
    step(1'b0, 1'b1, 1'b0, "t5.no_edge");
    chk("t5.no_hit", 32'(vidas), 32'd3);

    // Restart from game over with a hit edge in the same cycle
    step(1'b0, 1'b0, 1'b0, "t6.pre");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, "t6.hit");
      idle(5, "t6.gap");
    end
    chk("t6.over", 32'(fim_jogo), 32'd1);
    step(1'b1, 1'b1, 1'b0, "t6.restart");
    chk("t6.vidas", 32'(vidas), 32'd3);
    chk("t6.fim", 32'(fim_jogo), 32'd0);
    chk("t6.invul", 32'(invulneravel), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r == 0) async_reset(1'($urandom_range(0, 1)), "rnd.rst");
      else step(r < 8, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vida_regressiva.md
Name: vida_regressiva

Overview:
- Lives-remaining tracker for the game datapath; the consumer side of the life-count path.
- Loads a full life count on game start and decrements on each hit, with a short post-hit invulnerability window.
- Drives a thermometer LED bar and a game-over flag to the top-level game controller.
- Owns the start / playing / game-over sequencing for the life subsystem.

Parameters:
- MAX_VIDAS, 3: lives loaded at start. Range 1..(2**WIDTH - 1).
- WIDTH, 2: width of the vidas count.
- INVUL_CICLOS, 4: number of clock cycles after an accepted hit during which further hits are ignored. 0 disables the window.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. 0 resets the block immediately.
- iniciar, input, 1: start/restart request, level, sampled each clock.
- dano, input, 1: hit signal, level. Acts on its rising edge only.
- bonus, input, 1: extra-life signal, level. Acts on its rising edge only (see Optional Feature).
- vidas, output, WIDTH: lives remaining, registered.
- leds, output, MAX_VIDAS: thermometer of lives. leds[i] = 1 iff vidas > i.
- fim_jogo, output, 1: game over, registered.
- invulneravel, output, 1: 1 while the invulnerability timer is nonzero.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state = OCIOSO; vidas = 0; leds = 0; fim_jogo = 0; timer = 0; invulneravel = 0.
  - dano_q = 1 and bonus_q = 1, so a level already high at reset release does not count as an edge.
- Edge detect:
  - dano_q and bonus_q register the inputs every clock.
  - hit = dano & ~dano_q; extra = bonus & ~bonus_q. Both are evaluated on the same edge that samples the input.
- Priority: iniciar is highest, in every state.
  - If iniciar=1 at an edge: vidas <= MAX_VIDAS, timer <= 0, fim_jogo <= 0, state <= JOGANDO.
  - Any hit or extra in that cycle is discarded.
- OCIOSO: hit and extra are ignored. Stays until iniciar.
- JOGANDO:
  - hit is accepted when timer = 0. Effect: vidas <= vidas - 1, timer <= INVUL_CICLOS.
  - hit while timer != 0 is dropped, not queued.
  - extra: vidas <= vidas + 1, saturating at MAX_VIDAS.
  - Accepted hit and extra in the same cycle: net vidas unchanged, but timer still loads INVUL_CICLOS.
  - If an accepted hit leaves vidas = 0: state <= FIM and fim_jogo <= 1 on the same edge.
  - The timer counts down by 1 each cycle while nonzero. No underflow.
- FIM:
  - vidas holds at 0 and fim_jogo holds at 1.
  - hit and extra are ignored; the timer still drains to 0.
  - Leaves only via iniciar.
- Latency:
  - An input edge is seen at clock edge k; vidas, fim_jogo and timer change at that same edge k.
  - leds and invulneravel are combinational from registers, so they update alongside vidas and timer.
- Arithmetic: vidas never wraps. Decrement at 0 cannot occur (state is FIM); increment saturates.

Optional Feature:
- Macro: VIDA_BONUS_EN.
- Defined: bonus edge detection and the saturating increment behave as above.
- Undefined:
  - The bonus port is still present but ignored; bonus_q and the increment logic are not built.
  - vidas is monotonically non-increasing between iniciar events.

Test Plan:
1. Reset low then high, iniciar pulsed 1 cycle. Expected: vidas=0, leds=000 before the pulse; the edge after the pulse gives vidas=3, leds=111, fim_jogo=0.
2. In JOGANDO with vidas=3, three dano pulses spaced 6 cycles apart. Expected: vidas 3→2→1→0, leds 111→011→001→000; fim_jogo=1 on the third accepted edge; further dano pulses leave vidas=0.
3. Hit accepted, then a second dano rising edge 2 cycles later (timer≠0). Expected: second hit ignored, vidas stays 2. A third edge 5 cycles after the first is accepted, vidas=1.
4. VIDA_BONUS_EN defined:
   - vidas=2, bonus pulse → vidas=3.
   - Another bonus pulse → stays 3 (saturation).
   - dano and bonus rising together → vidas unchanged, invulneravel=1 for 4 cycles.
5. Reset asserted mid-game with vidas=1 and timer=3. Expected: all outputs 0 immediately, without waiting for a clock. dano held high through reset release produces no hit.
6. In FIM, iniciar with dano rising in the same cycle. Expected: vidas=3, fim_jogo=0, invulneravel=0, no decrement.
